// File: rtl/iq_pair_sched.sv
// iq_pair_sched: I/Q pair assembly, decimation and issue FIFO.
// Optional: IQ_OFFSET_BIN_EN treats input bytes as offset-binary.
module iq_pair_sched #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  data_i,
  input  logic        byte_valid_i,
  output logic [7:0]  i_o,
  output logic [7:0]  q_o,
  output logic        iq_valid_o,
  input  logic        iq_ready_i,
  output logic        busy_o,
  output logic [15:0] pair_cnt_o,
  output logic        overflow_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  DLAST = 8'(DECIM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXP_I,
    S_EXP_Q,
    S_DRAIN
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic [7:0]      r_ihold;
  logic [7:0]      r_dcnt;
  logic [15:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_fcnt;
  logic [15:0]     r_pcnt;
  logic            r_ovf;

  logic [7:0]      w_byte;
  logic            w_start;
  logic            w_pair;
  logic            w_hit;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

`ifdef IQ_OFFSET_BIN_EN
  assign w_byte = {~data_i[7], data_i[6:0]};
`else
  assign w_byte = data_i;
`endif

  assign w_start = (r_state == S_IDLE) && start_i;
  assign w_pair  = (r_state == S_EXP_Q) && start_i
                   && byte_valid_i;
  assign w_hit   = w_pair && (r_dcnt == DLAST);
  assign w_empty = (r_fcnt == '0);
  assign w_full  = (r_fcnt == FULL_CNT);
  assign w_pop   = !w_empty && iq_ready_i;
  // a full FIFO still takes the pair if a slot frees this cycle
  assign w_push  = w_hit && (!w_full || w_pop);
  assign w_drop  = w_hit && w_full && !w_pop;

  assign iq_valid_o = !w_empty;
  assign i_o        = r_mem[r_rd][15:8];
  assign q_o        = r_mem[r_rd][7:0];
  assign busy_o     = r_busy;
  assign pair_cnt_o = r_pcnt;
  assign overflow_o = r_ovf;

  // stream FSM: pairs bytes into I/Q, drains on stop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_ihold <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_EXP_I;
            r_busy  <= 1'b1;
          end
        end
        S_EXP_I: begin
          if (!start_i) begin
            r_state <= S_DRAIN;
          end else if (byte_valid_i) begin
            r_ihold <= w_byte;
            r_state <= S_EXP_Q;
          end
        end
        S_EXP_Q: begin
          if (!start_i) begin
            r_state <= S_DRAIN;
          end else if (byte_valid_i) begin
            r_state <= S_EXP_I;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // decimation counter: one pair kept per DECIM completed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dcnt <= '0;
    end else if (w_start) begin
      r_dcnt <= '0;
    end else if (w_pair) begin
      r_dcnt <= (r_dcnt == DLAST) ? 8'd0
                                  : r_dcnt + 8'd1;
    end
  end

  // issue FIFO storage and pointers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wr   <= '0;
      r_rd   <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= {r_ihold, w_byte};
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + 1'b1;
        2'b01:   r_fcnt <= r_fcnt - 1'b1;
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

  // issued-pair count and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_ovf  <= 1'b0;
    end else if (w_start) begin
      r_pcnt <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_pop) begin
        r_pcnt <= r_pcnt + 16'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iq_pair_sched.sv
// tb_iq_pair_sched: scoreboard bench, DECIM=1 and DECIM=4 copies
// driven by one shared byte stream.
module tb_iq_pair_sched;

  localparam int DEPTH = 4;
  localparam int M_IDLE = 0;
  localparam int M_EXPI = 1;
  localparam int M_EXPQ = 2;
  localparam int M_DRAIN = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  data;
  logic        bv;
  logic        rdy;

  logic [7:0]  o_i [2];
  logic [7:0]  o_q [2];
  logic        o_v [2];
  logic        o_b [2];
  logic [15:0] o_cnt [2];
  logic        o_ovf [2];

  int n_tot;
  int n_bad;

  int          st [2];
  int          dc [2];
  logic [7:0]  hi [2];
  logic [15:0] ecnt [2];
  logic        eovf [2];
  logic [15:0] sq0 [$];
  logic [15:0] sq1 [$];

  iq_pair_sched #(.DECIM(1), .FIFO_DEPTH(DEPTH)) u_d1 (
    .clk(clk), .rst(rst), .start_i(start),
    .data_i(data), .byte_valid_i(bv),
    .i_o(o_i[0]), .q_o(o_q[0]),
    .iq_valid_o(o_v[0]), .iq_ready_i(rdy),
    .busy_o(o_b[0]), .pair_cnt_o(o_cnt[0]),
    .overflow_o(o_ovf[0])
  );

  iq_pair_sched #(.DECIM(4), .FIFO_DEPTH(DEPTH)) u_d4 (
    .clk(clk), .rst(rst), .start_i(start),
    .data_i(data), .byte_valid_i(bv),
    .i_o(o_i[1]), .q_o(o_q[1]),
    .iq_valid_o(o_v[1]), .iq_ready_i(rdy),
    .busy_o(o_b[1]), .pair_cnt_o(o_cnt[1]),
    .overflow_o(o_ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] conv(input logic [7:0] b);
`ifdef IQ_OFFSET_BIN_EN
    return {~b[7], b[6:0]};
`else
    return b;
`endif
  endfunction

  function automatic int qsz(input int k);
    return (k == 0) ? sq0.size() : sq1.size();
  endfunction

  function automatic logic [15:0] qfront(input int k);
    return (k == 0) ? sq0[0] : sq1[0];
  endfunction

  function automatic void qpush(input int k,
                                input logic [15:0] v);
    if (k == 0) sq0.push_back(v);
    else sq1.push_back(v);
  endfunction

  function automatic void qpop(input int k);
    if (k == 0) void'(sq0.pop_front());
    else void'(sq1.pop_front());
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      st[k] = M_IDLE;
      dc[k] = 0;
      hi[k] = '0;
      ecnt[k] = '0;
      eovf[k] = 1'b0;
    end
    sq0.delete();
    sq1.delete();
  endfunction

  // expected behaviour of the coming clock edge
  function automatic void model_step(input int k);
    int  d;
    bit  empty_pre;
    bit  pop;
    d = (k == 0) ? 1 : 4;
    empty_pre = (qsz(k) == 0);
    pop = !empty_pre && rdy;
    if (pop) begin
      qpop(k);
      ecnt[k] = ecnt[k] + 16'd1;
    end
    case (st[k])
      M_IDLE: if (start) begin
        st[k] = M_EXPI;
        ecnt[k] = '0;
        eovf[k] = 1'b0;
        dc[k] = 0;
      end
      M_EXPI: if (!start) st[k] = M_DRAIN;
        else if (bv) begin
          hi[k] = conv(data);
          st[k] = M_EXPQ;
        end
      M_EXPQ: if (!start) st[k] = M_DRAIN;
        else if (bv) begin
          if (dc[k] == d - 1) begin
            dc[k] = 0;
            if (qsz(k) < DEPTH) qpush(k, {hi[k], conv(data)});
            else eovf[k] = 1'b1;
          end else begin
            dc[k] = dc[k] + 1;
          end
          st[k] = M_EXPI;
        end
      default: if (empty_pre) st[k] = M_IDLE;
    endcase
  endfunction

  // compare outputs, advance model, run one clock
  task automatic cyc();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(o_b[k]),
          32'(st[k] != M_IDLE));
      chk($sformatf("valid%0d", k), 32'(o_v[k]),
          32'(qsz(k) != 0));
      chk($sformatf("cnt%0d", k), 32'(o_cnt[k]),
          32'(ecnt[k]));
      chk($sformatf("ovf%0d", k), 32'(o_ovf[k]),
          32'(eovf[k]));
      if (qsz(k) != 0) begin
        chk($sformatf("pair%0d", k),
            32'({o_i[k], o_q[k]}), 32'(qfront(k)));
      end
      model_step(k);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    data = b;
    bv = 1'b1;
    cyc();
  endtask

  task automatic idle(input int n);
    bv = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic go();
    start = 1'b1;
    bv = 1'b0;
    cyc();
  endtask

  task automatic stop_drain(input int n);
    start = 1'b0;
    idle(n);
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst = 1'b0;
    start = 1'b0;
    data = '0;
    bv = 1'b0;
    rdy = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_i", 32'(o_i[k]), 32'd0);
      chk("rst_q", 32'(o_q[k]), 32'd0);
      chk("rst_valid", 32'(o_v[k]), 32'd0);
      chk("rst_busy", 32'(o_b[k]), 32'd0);
      chk("rst_cnt", 32'(o_cnt[k]), 32'd0);
      chk("rst_ovf", 32'(o_ovf[k]), 32'd0);
    end
    rst = 1'b1;

    // basic pass-through
    rdy = 1'b1;
    go();
    chk("start_busy", 32'(o_b[0]), 32'd1);
    send(8'sd10);
    send(-8'sd20);
    send(8'sd30);
    send(-8'sd40);
    stop_drain(6);
    chk("t1_cnt", 32'(o_cnt[0]), 32'd2);
    chk("t1_idle", 32'(o_b[0]), 32'd0);

    // decimation by 4
    go();
    for (int k = 1; k <= 8; k++) begin
      send(8'(k));
      send(8'(-k));
    end
    stop_drain(8);
    chk("t2_cnt4", 32'(o_cnt[1]), 32'd2);
    chk("t2_cnt1", 32'(o_cnt[0]), 32'd8);

    // overflow with ready held low
    rdy = 1'b0;
    go();
    for (int k = 0; k < 6; k++) begin
      send(8'(20 + k));
      send(8'(-(20 + k)));
    end
    stop_drain(3);
    chk("t3_hold", 32'(o_v[0]), 32'd1);
    chk("t3_ovf", 32'(o_ovf[0]), 32'd1);
    chk("t3_ovf4", 32'(o_ovf[1]), 32'd0);
    rdy = 1'b1;
    idle(8);
    chk("t3_cnt", 32'(o_cnt[0]), 32'd4);
    chk("t3_idle", 32'(o_b[0]), 32'd0);

    // stop after a lone I byte
    go();
    send(8'd1);
    send(8'd2);
    send(8'd55);
    start = 1'b0;
    send(8'd66);
    idle(8);
    chk("t4_busy", 32'(o_b[0]), 32'd0);
    chk("t4_cnt", 32'(o_cnt[0]), 32'd1);

    // reset mid-stream with pairs queued
    rdy = 1'b0;
    go();
    for (int k = 0; k < 3; k++) begin
      send(8'(40 + k));
      send(8'(50 + k));
    end
    chk("t5_queued", 32'(o_v[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_valid", 32'(o_v[0]), 32'd0);
    chk("t5_cnt", 32'(o_cnt[0]), 32'd0);
    chk("t5_busy", 32'(o_b[0]), 32'd0);
    chk("t5_i", 32'(o_i[0]), 32'd0);
    model_reset();
    start = 1'b0;
    bv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy = 1'b1;
    go();
    send(8'd7);
    send(8'd8);
    stop_drain(6);
    chk("t5_resume", 32'(o_cnt[0]), 32'd1);

`ifdef IQ_OFFSET_BIN_EN
    go();
    send(8'h80);
    send(8'hFF);
    stop_drain(6);
`endif

    // random traffic, start drops and backpressure
    for (int n = 0; n < 400; n++) begin
      rdy = ($urandom_range(0, 3) != 0);
      bv = $urandom_range(0, 1) == 1;
      data = 8'($urandom);
      if (start) start = ($urandom_range(0, 29) != 0);
      else start = ($urandom_range(0, 4) == 0);
      cyc();
    end
    stop_drain(12);
    chk("end_idle0", 32'(o_b[0]), 32'd0);
    chk("end_idle1", 32'(o_b[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/iq_pair_sched.md
# iq_pair_sched

Input-side controller for the FM demodulator datapath. Takes the raw interleaved I/Q byte stream (I, Q, I, Q, …) gated by `start_i`, assembles I/Q pairs, applies integer decimation, and issues pairs to the demodulator core through a ready/valid handshake buffered by a small FIFO. Sits between the byte source and the demodulator core; reports busy, pair count and sticky overflow status.

## Interface
- `DECIM`, 4: decimation factor; one of every DECIM complete pairs is issued; legal 1..255.
- `FIFO_DEPTH`, 4: issue FIFO depth in pairs; power of two, 2..16.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `start_i` input 1: stream enable; level-sensitive.
- `data_i` input 8: signed input byte.
- `byte_valid_i` input 1: `data_i` valid this cycle.
- `i_o` output 8: signed I sample of issued pair.
- `q_o` output 8: signed Q sample of issued pair.
- `iq_valid_o` output 1: pair on `i_o`/`q_o` valid.
- `iq_ready_i` input 1: demodulator core accepts the pair.
- `busy_o` output 1: FSM not in IDLE.
- `pair_cnt_o` output 16: count of pairs issued since the last start.
- `overflow_o` output 1: sticky; a decimated pair was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, EXP_I, EXP_Q, DRAIN.
- IDLE: `start_i`=1 -> EXP_I. On this transition, clear `pair_cnt_o`, `overflow_o` and the decimation counter.
- EXP_I: a byte with `byte_valid_i`=1 latches into the I holding register -> EXP_Q.
- EXP_Q: a byte with `byte_valid_i`=1 completes the pair -> EXP_I.
  - If decimation counter == DECIM-1: push {I,Q} to the FIFO and reset the counter to 0.
  - Otherwise: increment the counter; the pair is discarded.
- `start_i`=0 in EXP_I or EXP_Q -> DRAIN. A half pair (I held, Q missing) is discarded. Bytes are ignored from this cycle on.
- DRAIN: no pushes. Leave to IDLE when the FIFO is empty. `start_i`=1 in DRAIN has no effect until IDLE is reached.
- Bytes arriving while in IDLE or DRAIN are ignored.
- Push with the FIFO full and no pop in the same cycle: drop the pair and set `overflow_o`. The counter still resets.
- Push with the FIFO full and a pop in the same cycle: accept the push.
- FIFO head drives `i_o`/`q_o`. `iq_valid_o` = FIFO non-empty.
- Pop occurs on `iq_valid_o && iq_ready_i`. Each pop increments `pair_cnt_o`, which wraps 0xFFFF -> 0.
- Data is never modified in the default build; sign is preserved.
- `rst` asserted (low), including mid-stream: FSM -> IDLE, FIFO emptied, pending pairs lost.

## Timing
- Reset values: `i_o`=0, `q_o`=0, `iq_valid_o`=0, `busy_o`=0, `pair_cnt_o`=0, `overflow_o`=0.
- Start latency: `start_i` rising -> `busy_o`=1 one cycle later. The first byte accepted is the one present in the cycle after IDLE is left.
- Issue latency: Q byte accepted on edge N -> `iq_valid_o`=1 after edge N when the FIFO was empty.
- Throughput: one pair per two valid bytes; `byte_valid_i` may be held at 1 continuously.
- `i_o`/`q_o` are held stable while `iq_valid_o`=1 and `iq_ready_i`=0.
- `overflow_o` and `pair_cnt_o` update on the edge of the causing event.

## Configuration
- `IQ_OFFSET_BIN_EN` defined: `data_i` is treated as unsigned offset-binary (128 = zero). Each byte has its MSB inverted before latching, so 0x80 maps to 0x00 and 0xFF to 0x7F.
- `IQ_OFFSET_BIN_EN` undefined: bytes pass through unchanged as two's complement.

## Test plan
- Default build, DECIM=1, `iq_ready_i`=1, stream 10,-20,30,-40 -> pairs (10,-20) then (30,-40) issued; `pair_cnt_o`=2.
- DECIM=4, 16 bytes forming pairs (k,-k) for k=1..8 -> only (4,-4) and (8,-8) issued; `pair_cnt_o`=2.
- `iq_ready_i`=0, DECIM=1, FIFO_DEPTH=4, 6 pairs -> 4 held, `overflow_o`=1. Raise ready -> the first 4 pairs drain in order; `pair_cnt_o`=4.
- `start_i` dropped after the I byte 55 -> 55 never issued; DRAIN then IDLE; `busy_o`=0 once the FIFO is empty.
- `rst` pulsed low with 3 pairs queued -> `iq_valid_o`=0 immediately, `pair_cnt_o`=0, FSM IDLE; the next start resumes with an I byte.
- With `IQ_OFFSET_BIN_EN`, DECIM=1, bytes 0x80,0xFF -> pair (0,127).
